// File: rtl/usrt_tx_framer_if.sv
// rtl/usrt_tx_framer_if.sv - write-side bus of the USRT transmit framer
//
// Purpose: groups the byte-queue write path and its status flags.
// Signals:
//   wr_en    write strobe, one byte pushed per cycle high
//   wr_data  byte to queue
//   ovr_clr  clears the sticky overflow flag
//   full     queue holds DEPTH bytes
//   empty    queue holds no bytes
//   level    bytes queued, excluding the frame in flight
//   ovr      sticky overflow flag
// Modports: master drives writes (APB side), slave is the framer.
interface usrt_tx_framer_if #(
   parameter int LW = 3
) ();
   logic          wr_en;
   logic [7:0]    wr_data;
   logic          ovr_clr;
   logic          full;
   logic          empty;
   logic [LW-1:0] level;
   logic          ovr;

   modport master (
      output wr_en, wr_data, ovr_clr,
      input  full, empty, level, ovr
   );

   modport slave (
      input  wr_en, wr_data, ovr_clr,
      output full, empty, level, ovr
   );
endinterface

// File: rtl/usrt_tx_framer.sv
// rtl/usrt_tx_framer.sv - byte FIFO plus 11-bit USRT frame serializer
//
// Purpose: queues bytes from the APB write path and shifts each one out as
// start(1), 8 data bits LSB first, parity (XOR of data), stop(0). Line idles 0.
// Bit times are paced by the single-cycle baud tick.
// Ports:
//   pClk    system clock
//   uRst    synchronous active-high reset
//   tick    baud tick, one bit time per tick interval
//   en      transmit enable, gates frame start only
//   wr_bus  write path and queue status (usrt_tx_framer_if.slave)
//   Tx      registered serial line
//   busy    a frame is on the line
module usrt_tx_framer #(
   parameter int DEPTH = 4,
   parameter int LW    = 3
) (
   input  logic              pClk,
   input  logic              uRst,
   input  logic              tick,
   input  logic              en,
   usrt_tx_framer_if.slave   wr_bus,
   output logic              Tx,
   output logic              busy
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [LW-1:0] level_q;
   logic [LW-1:0] level_d;
   logic          full_q;
   logic          empty_q;
   logic          ovr_q;

   state_t        state_q;
   state_t        state_d;
   logic [2:0]    bitcnt_q;
   logic [2:0]    bitcnt_d;
   logic [7:0]    shift_q;
   logic [7:0]    shift_d;
   logic          par_q;
   logic          par_d;
   logic          tx_q;
   logic          tx_d;
   logic          busy_q;

   logic          launch;
   logic          push;
   logic          pop;
   logic [7:0]    head;

   // A frame may start from IDLE or straight out of STOP (back-to-back).
   // empty_q is registered, so a byte written on a tick cycle cannot launch
   // on that same tick.
   assign launch = tick && en && !empty_q && (state_q == IDLE || state_q == STOP);
   assign pop    = launch;
   assign push   = wr_bus.wr_en && !full_q;
   assign head   = mem[rd_ptr];

   // ---------------- FIFO ----------------
   always_ff @(posedge pClk) begin
      if (push) begin
         mem[wr_ptr] <= wr_bus.wr_data;
      end
   end

   always_comb begin
      level_d = level_q;
      if (push && !pop) begin
         level_d = level_q + LW'(1);
      end else if (pop && !push) begin
         level_d = level_q - LW'(1);
      end
   end

   always_ff @(posedge pClk) begin
      if (uRst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         ovr_q   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         level_q <= level_d;
         full_q  <= (level_d == LW'(DEPTH));
         empty_q <= (level_d == '0);
         // Overflow is judged on the registered full flag, so a pop in the
         // same cycle does not rescue the byte; set beats clear.
         if (wr_bus.wr_en && full_q) begin
            ovr_q <= 1'b1;
         end else if (wr_bus.ovr_clr) begin
            ovr_q <= 1'b0;
         end
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge pClk) begin
      if (uRst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (tick) begin
         case (state_q)
            IDLE:    state_d = launch ? START : IDLE;
            START:   state_d = DATA;
            DATA:    state_d = (bitcnt_q == 3'd7) ? PARITY : DATA;
            PARITY:  state_d = STOP;
            STOP:    state_d = launch ? START : IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs / datapath next values ----------------
   always_comb begin
      tx_d     = tx_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      par_d    = par_q;
      if (tick) begin
         case (state_q)
            IDLE, STOP: begin
               if (launch) begin
                  shift_d = head;
                  par_d   = ^head;
                  tx_d    = 1'b1;
               end else begin
                  tx_d    = 1'b0;
               end
            end
            START: begin
               tx_d     = shift_q[0];
               bitcnt_d = 3'd0;
            end
            DATA: begin
               if (bitcnt_q != 3'd7) begin
                  tx_d     = shift_q[bitcnt_q + 3'd1];
                  bitcnt_d = bitcnt_q + 3'd1;
               end else begin
                  tx_d     = par_q;
               end
            end
            PARITY: begin
               tx_d = 1'b0;
            end
            default: begin
               tx_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge pClk) begin
      if (uRst) begin
         tx_q     <= 1'b0;
         bitcnt_q <= 3'd0;
         shift_q  <= 8'd0;
         par_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         tx_q     <= tx_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         busy_q   <= (state_d != IDLE);
      end
   end

   assign Tx           = tx_q;
   assign busy         = busy_q;
   assign wr_bus.full  = full_q;
   assign wr_bus.empty = empty_q;
   assign wr_bus.level = level_q;
   assign wr_bus.ovr   = ovr_q;

endmodule

// File: tb/tb_usrt_tx_framer.sv
// tb/tb_usrt_tx_framer.sv - directed self-checking bench for usrt_tx_framer
module tb_usrt_tx_framer;

   logic pClk = 1'b0;
   logic uRst;
   logic tick;
   logic en;
   logic Tx;
   logic busy;

   int errors   = 0;
   int checks   = 0;
   int tick_per = 128;
   int tcnt     = 0;

   usrt_tx_framer_if #(.LW(3)) bus ();

   usrt_tx_framer #(.DEPTH(4), .LW(3)) dut (
      .pClk   (pClk),
      .uRst   (uRst),
      .tick   (tick),
      .en     (en),
      .wr_bus (bus),
      .Tx     (Tx),
      .busy   (busy)
   );

   always #5 pClk = ~pClk;

   // Tick source: changes only on the falling edge.
   initial begin
      tick = 1'b0;
      forever begin
         @(negedge pClk);
         if (tick_per <= 1) begin
            tick = 1'b1;
         end else begin
            tick = (tcnt == 0);
            tcnt = (tcnt + 1) % tick_per;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected line level for bit i of a frame carrying d.
   function automatic logic fbit(input logic [7:0] d, input int i);
      if (i == 0)       return 1'b1;
      else if (i <= 8)  return d[i-1];
      else if (i == 9)  return ^d;
      else              return 1'b0;
   endfunction

   // Wait for the next edge that samples tick=1 and return the line after it.
   task automatic get_bit(output logic b, output logic bz);
      int n;
      n = 0;
      @(posedge pClk);
      while (!tick && n < 2000) begin
         n++;
         @(posedge pClk);
      end
      if (!tick) check("tick_timeout", 32'd0, 32'd1);
      #1;
      b  = Tx;
      bz = busy;
   endtask

   task automatic write_byte(input logic [7:0] d);
      @(negedge pClk);
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      @(negedge pClk);
      bus.wr_en   = 1'b0;
   endtask

   // Collect one frame; drop_at >= 0 clears en right after that bit.
   task automatic frame_chk(input string tag, input logic [7:0] d, input int drop_at);
      logic [10:0] got;
      logic [10:0] exp;
      logic        busy_all;
      logic        b;
      logic        bz;
      busy_all = 1'b1;
      for (int i = 0; i < 11; i++) begin
         get_bit(b, bz);
         got[i]   = b;
         exp[i]   = fbit(d, i);
         busy_all = busy_all & bz;
         if (i == drop_at) en = 1'b0;
      end
      check(tag, {21'd0, got}, {21'd0, exp});
      check({tag, "_busy"}, {31'd0, busy_all}, 32'd1);
   endtask

   task automatic idle_chk(input string tag);
      logic b;
      logic bz;
      get_bit(b, bz);
      check({tag, "_tx"}, {31'd0, b}, 32'd0);
      check({tag, "_busy"}, {31'd0, bz}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      uRst        = 1'b1;
      en          = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_data = 8'h00;
      bus.ovr_clr = 1'b0;
      repeat (3) @(posedge pClk);
      @(negedge pClk);
      check("rst_tx",    {31'd0, Tx},        32'd0);
      check("rst_busy",  {31'd0, busy},      32'd0);
      check("rst_full",  {31'd0, bus.full},  32'd0);
      check("rst_empty", {31'd0, bus.empty}, 32'd1);
      check("rst_level", {29'd0, bus.level}, 32'd0);
      check("rst_ovr",   {31'd0, bus.ovr},   32'd0);
      uRst = 1'b0;

      // Single byte, slow ticks.
      tick_per = 128;
      en = 1'b1;
      write_byte(8'hA5);
      frame_chk("a5_frame", 8'hA5, -1);
      check("a5_level", {29'd0, bus.level}, 32'd0);
      idle_chk("a5_idle");

      // Back-to-back frames, no idle bit between them.
      tick_per = 16;
      write_byte(8'h01);
      write_byte(8'hFF);
      frame_chk("b2b_01", 8'h01, -1);
      frame_chk("b2b_ff", 8'hFF, -1);
      idle_chk("b2b_idle");

      // Overflow with transmit disabled.
      tick_per = 8;
      en = 1'b0;
      write_byte(8'h11);
      write_byte(8'h22);
      write_byte(8'h33);
      write_byte(8'h44);
      check("ovf_full4",  {31'd0, bus.full},  32'd1);
      check("ovf_level4", {29'd0, bus.level}, 32'd4);
      check("ovf_ovr4",   {31'd0, bus.ovr},   32'd0);
      write_byte(8'h55);
      check("ovf_ovr5",   {31'd0, bus.ovr},   32'd1);
      check("ovf_level5", {29'd0, bus.level}, 32'd4);
      @(negedge pClk);
      bus.ovr_clr = 1'b1;
      @(negedge pClk);
      bus.ovr_clr = 1'b0;
      check("ovf_clr", {31'd0, bus.ovr}, 32'd0);
      en = 1'b1;
      frame_chk("ovf_11", 8'h11, -1);
      frame_chk("ovf_22", 8'h22, -1);
      frame_chk("ovf_33", 8'h33, -1);
      frame_chk("ovf_44", 8'h44, -1);
      idle_chk("ovf_idle");
      check("ovf_empty", {31'd0, bus.empty}, 32'd1);

      // Enable dropped mid-frame.
      en = 1'b0;
      write_byte(8'h5A);
      write_byte(8'hC3);
      @(negedge pClk);
      en = 1'b1;
      frame_chk("drop_5a", 8'h5A, 3);
      idle_chk("drop_idle1");
      idle_chk("drop_idle2");
      check("drop_level", {29'd0, bus.level}, 32'd1);
      @(negedge pClk);
      en = 1'b1;
      frame_chk("drop_c3", 8'hC3, -1);
      idle_chk("drop_idle3");

      // Reset in the middle of DATA with a byte still queued.
      tick_per = 4;
      write_byte(8'h96);
      begin
         logic b;
         logic bz;
         get_bit(b, bz);
         get_bit(b, bz);
         write_byte(8'h77);
         get_bit(b, bz);
         get_bit(b, bz);
      end
      @(negedge pClk);
      uRst = 1'b1;
      @(posedge pClk);
      #1;
      check("mrst_tx",    {31'd0, Tx},        32'd0);
      check("mrst_busy",  {31'd0, busy},      32'd0);
      check("mrst_level", {29'd0, bus.level}, 32'd0);
      check("mrst_empty", {31'd0, bus.empty}, 32'd1);
      @(negedge pClk);
      uRst = 1'b0;

      // Continuous tick: one bit per cycle; the write-cycle tick must not launch.
      tick_per = 1;
      repeat (2) @(negedge pClk);
      write_byte(8'h3C);
      check("cont_nolaunch", {31'd0, Tx}, 32'd0);
      frame_chk("cont_3c", 8'h3C, -1);
      idle_chk("cont_idle");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
